// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the pipeline stall/flush sequencer
//
// Purpose : FSM state type, the architectural zero register index and the
//           default performance counter width used by pipeline_ctrl.
// Ports   : none (package).
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         DEFAULT_CNT_W = 32;

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - free-running event counter with synchronous clear
//
// Purpose : CNT_W-bit counter; clear has priority over increment and the
//           count wraps modulo 2^CNT_W.
// Ports   : clk     - clock
//           clr_i   - synchronous clear
//           inc_i   - increment enable
//           count_o - current count
module perf_counter
  import pipeline_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
//
// Purpose : Resolves hazards forwarding cannot cover (memory wait, MUL/DIV
//           occupancy, taken redirect, load-use) into per-stage enables and
//           bubble-insert flushes, counts stall cycles and redirect flushes,
//           and bounds MUL/DIV waits with a sticky watchdog error.
// Ports   : clk, rst                      - clock, sync active-high reset
//           id_rs1_addr/id_rs2_addr       - ID source registers
//           id_uses_rs1/id_uses_rs2       - ID really reads that source
//           id_ex_rd_addr, id_ex_memread  - EX destination / EX is a load
//           ex_redirect                   - taken branch/jump in EX
//           ex_muldiv_start, muldiv_done  - MUL/DIV start / result pulses
//           dmem_req, dmem_ready          - MEM access / access completes
//           *_en, *_flush                 - register enables and bubble loads
//           stall_cycles, flush_events    - performance counters
//           md_timeout_err                - sticky watchdog error
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_ex_rd_addr,
  input  logic             id_ex_memread,
  input  logic             ex_redirect,
  input  logic             ex_muldiv_start,
  input  logic             muldiv_done,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             md_timeout_err
);

  localparam int              WD_W    = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

  ctrl_state_t     state_q;
  logic            md_pending_q;  // MD wait interrupted by a memory wait, unit not yet done
  logic [WD_W-1:0] wd_q;
  logic            err_q;

  logic haz_mem, haz_md, haz_br, haz_lu;
  logic br_act;

  always_comb begin
    haz_mem = dmem_req && !dmem_ready;
    haz_md  = ((state_q == RUN) && ex_muldiv_start) ||
              ((state_q == MD_WAIT) && !muldiv_done);
    haz_br  = (state_q == RUN) && ex_redirect;
    haz_lu  = id_ex_memread && (id_ex_rd_addr != REG_ZERO) &&
              ((id_uses_rs1 && (id_rs1_addr == id_ex_rd_addr)) ||
               (id_uses_rs2 && (id_rs2_addr == id_ex_rd_addr)));
  end

  // One action per cycle, highest priority first; nothing stalls in reset.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    br_act       = 1'b0;
    if (!rst) begin
      if (haz_mem) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_flush = 1'b1;
      end else if (haz_md) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_flush = 1'b1;
      end else if (haz_br) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        br_act       = 1'b1;
      end else if (haz_lu) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_flush  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      md_pending_q <= 1'b0;
      wd_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          wd_q <= '0;
          if (haz_mem) begin
            state_q      <= MEM_WAIT;
            md_pending_q <= ex_muldiv_start;
          end else if (ex_muldiv_start) begin
            state_q <= MD_WAIT;
          end
        end
        MD_WAIT: begin
          if (haz_mem) begin
            state_q      <= MEM_WAIT;
            md_pending_q <= !muldiv_done;
            wd_q         <= '0;
          end else if (muldiv_done) begin
            state_q <= RUN;
            wd_q    <= '0;
          end else if (wd_q == WD_LAST) begin
            state_q <= RUN;
            err_q   <= 1'b1;
            wd_q    <= '0;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        MEM_WAIT: begin
          wd_q <= '0;
          // Leave as soon as the memory condition clears; a done seen in
          // the wait (this cycle or earlier) cancels the pending MD wait.
          if (!haz_mem) begin
            state_q      <= (md_pending_q && !muldiv_done) ? MD_WAIT : RUN;
            md_pending_q <= 1'b0;
          end else if (muldiv_done) begin
            md_pending_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= RUN;
          md_pending_q <= 1'b0;
          wd_q         <= '0;
        end
      endcase
    end
  end

  assign md_timeout_err = err_q;

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .clr_i   (rst),
    .inc_i   (!pc_en),
    .count_o (stall_cycles)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .clr_i   (rst),
    .inc_i   (br_act),
    .count_o (flush_events)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam int CNT_W      = 32;
  localparam int MD_TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_ex_rd_addr;
  logic id_uses_rs1, id_uses_rs2, id_ex_memread, ex_redirect;
  logic ex_muldiv_start, muldiv_done, dmem_req, dmem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic md_timeout_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(CNT_W), .MD_TIMEOUT(MD_TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .id_ex_rd_addr  (id_ex_rd_addr),
    .id_ex_memread  (id_ex_memread),
    .ex_redirect    (ex_redirect),
    .ex_muldiv_start(ex_muldiv_start),
    .muldiv_done    (muldiv_done),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .id_ex_en       (id_ex_en),
    .ex_mem_en      (ex_mem_en),
    .mem_wb_en      (mem_wb_en),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_flush   (ex_mem_flush),
    .mem_wb_flush   (mem_wb_flush),
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events),
    .md_timeout_err (md_timeout_err)
  );

  logic [4:0] en_v;
  logic [3:0] fl_v;
  assign en_v = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  assign fl_v = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, redir, mds, dreq, drdy;
    logic [4:0] en;
    logic [3:0] fl;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic u1, input logic u2, input logic mr,
                              input logic redir, input logic mds, input logic dreq,
                              input logic drdy, input logic [4:0] en, input logic [3:0] fl);
    vec_t v;
    v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.u1 = u1; v.u2 = u2; v.mr = mr;
    v.redir = redir; v.mds = mds; v.dreq = dreq; v.drdy = drdy; v.en = en; v.fl = fl;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_ex_rd_addr = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_ex_memread = 1'b0;
    ex_redirect = 1'b0; ex_muldiv_start = 1'b0; muldiv_done = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    id_rs1_addr = v.rs1; id_rs2_addr = v.rs2; id_ex_rd_addr = v.rd;
    id_uses_rs1 = v.u1; id_uses_rs2 = v.u2; id_ex_memread = v.mr;
    ex_redirect = v.redir; ex_muldiv_start = v.mds; muldiv_done = 1'b0;
    dmem_req = v.dreq; dmem_ready = v.drdy;
  endtask

  task automatic expect_out(input string name, input logic [4:0] en, input logic [3:0] fl);
    @(negedge clk);
    check({name, "_en"}, 64'(en_v), 64'(en));
    check({name, "_fl"}, 64'(fl_v), 64'(fl));
  endtask

  // Reference model state: an outstanding MUL/DIV op and an ongoing memory wait.
  bit          m_in_mem, m_md_busy, m_err;
  int          m_wd;
  int unsigned m_stall, m_flush;

  task automatic model_cycle(output logic [4:0] e_en, output logic [3:0] e_fl);
    bit run_mode, md_mode, mem, md, br, lu, done;
    run_mode = !m_in_mem && !m_md_busy;
    md_mode  = !m_in_mem && m_md_busy;
    done     = muldiv_done;
    mem = dmem_req && !dmem_ready;
    md  = (run_mode && ex_muldiv_start) || (md_mode && !done);
    br  = run_mode && ex_redirect;
    lu  = id_ex_memread && id_ex_rd_addr != 0 &&
          ((id_uses_rs1 && id_rs1_addr == id_ex_rd_addr) ||
           (id_uses_rs2 && id_rs2_addr == id_ex_rd_addr));
    e_en = 5'b11111;
    e_fl = 4'b0000;
    if (rst) begin
      m_in_mem = 0; m_md_busy = 0; m_err = 0; m_wd = 0; m_stall = 0; m_flush = 0;
      return;
    end
    if (mem)      begin e_en = 5'b00001; e_fl = 4'b0001; end
    else if (md)  begin e_en = 5'b00011; e_fl = 4'b0010; end
    else if (br)  begin e_fl = 4'b1100; m_flush++; end
    else if (lu)  begin e_en = 5'b00111; e_fl = 4'b0100; end
    if (e_en[4] == 1'b0) m_stall++;
    if (mem) begin
      m_md_busy = md || (m_in_mem && m_md_busy && !done);
      m_in_mem  = 1;
      m_wd      = 0;
    end else if (m_in_mem) begin
      m_in_mem  = 0;
      m_md_busy = m_md_busy && !done;
      m_wd      = 0;
    end else if (run_mode) begin
      m_md_busy = ex_muldiv_start;
      m_wd      = 0;
    end else if (done) begin
      m_md_busy = 0;
      m_wd      = 0;
    end else begin
      m_wd++;
      if (m_wd == MD_TIMEOUT) begin
        m_err = 1; m_md_busy = 0; m_wd = 0;
      end
    end
  endtask

  initial begin
    int stalled;
    logic [4:0] e_en;
    logic [3:0] e_fl;

    vecs[0]  = mk("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 4'b0000);
    vecs[1]  = mk("lu_rs1",    5, 0, 5, 1, 0, 1, 0, 0, 0, 0, 5'b00111, 4'b0100);
    vecs[2]  = mk("lu_x0",     0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 5'b11111, 4'b0000);
    vecs[3]  = mk("lu_unused", 0, 7, 7, 0, 0, 1, 0, 0, 0, 0, 5'b11111, 4'b0000);
    vecs[4]  = mk("lu_rs2",    1, 7, 7, 1, 1, 1, 0, 0, 0, 0, 5'b00111, 4'b0100);
    vecs[5]  = mk("no_load",   5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 5'b11111, 4'b0000);
    vecs[6]  = mk("br",        0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11111, 4'b1100);
    vecs[7]  = mk("br_lu",     5, 0, 5, 1, 0, 1, 1, 0, 0, 0, 5'b11111, 4'b1100);
    vecs[8]  = mk("md_start",  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 5'b00011, 4'b0010);
    vecs[9]  = mk("mem",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 4'b0001);
    vecs[10] = mk("mem_all",   5, 0, 5, 1, 0, 1, 1, 1, 1, 0, 5'b00001, 4'b0001);
    vecs[11] = mk("mem_ready", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11111, 4'b0000);

    // Reset: hazards driven while rst=1 must not stall.
    rst = 1'b1;
    idle();
    dmem_req = 1'b1;
    ex_muldiv_start = 1'b1;
    tick();
    tick();
    expect_out("rst_hold", 5'b11111, 4'b0000);
    check("rst_stall_cnt", 64'(stall_cycles), 64'd0);
    check("rst_flush_cnt", 64'(flush_events), 64'd0);
    check("rst_err", 64'(md_timeout_err), 64'd0);
    tick();

    for (int i = 0; i < 12; i++) begin
      do_reset();
      drive(vecs[i]);
      expect_out(vecs[i].name, vecs[i].en, vecs[i].fl);
      tick();
    end

    // Load-use: one stall cycle.
    do_reset();
    drive(vecs[1]);
    expect_out("lu_seq", 5'b00111, 4'b0100);
    tick(); idle();
    expect_out("lu_after", 5'b11111, 4'b0000);
    check("lu_stall_cnt", 64'(stall_cycles), 64'd1);
    tick();

    // Redirect with load-use: no stall, one flush event.
    do_reset();
    drive(vecs[7]);
    expect_out("brlu_seq", 5'b11111, 4'b1100);
    tick(); idle();
    @(negedge clk);
    check("br_flush_cnt", 64'(flush_events), 64'd1);
    check("br_stall_cnt", 64'(stall_cycles), 64'd0);
    tick();

    // MUL/DIV: start, done 5 cycles later.
    do_reset();
    ex_muldiv_start = 1'b1;
    expect_out("md_c0", 5'b00011, 4'b0010);
    tick(); idle();
    for (int c = 1; c < 5; c++) begin
      expect_out("md_wait", 5'b00011, 4'b0010);
      tick();
    end
    muldiv_done = 1'b1;
    expect_out("md_done", 5'b11111, 4'b0000);
    tick(); idle();
    expect_out("md_after", 5'b11111, 4'b0000);
    check("md_stall_cnt", 64'(stall_cycles), 64'd5);
    tick();

    // Memory wait for 3 cycles.
    do_reset();
    dmem_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      expect_out("mem_wait", 5'b00001, 4'b0001);
      tick();
    end
    dmem_ready = 1'b1;
    expect_out("mem_rel", 5'b11111, 4'b0000);
    tick(); idle();
    ex_redirect = 1'b1;
    expect_out("mem_run", 5'b11111, 4'b1100);
    check("mem_stall_cnt", 64'(stall_cycles), 64'd3);
    tick();

    // MUL/DIV start coincident with memory wait: MD remembered and resumed.
    do_reset();
    ex_muldiv_start = 1'b1; dmem_req = 1'b1;
    expect_out("mdmem_c0", 5'b00001, 4'b0001);
    tick(); ex_muldiv_start = 1'b0;
    expect_out("mdmem_c1", 5'b00001, 4'b0001);
    tick(); dmem_ready = 1'b1;
    expect_out("mdmem_rel", 5'b11111, 4'b0000);
    tick(); idle();
    expect_out("mdmem_resume", 5'b00011, 4'b0010);
    tick(); muldiv_done = 1'b1;
    expect_out("mdmem_done", 5'b11111, 4'b0000);
    tick(); idle(); ex_redirect = 1'b1;
    expect_out("mdmem_run", 5'b11111, 4'b1100);
    tick();

    // muldiv_done during the memory wait is latched; MD_WAIT not re-entered.
    do_reset();
    ex_muldiv_start = 1'b1;
    expect_out("latch_c0", 5'b00011, 4'b0010);
    tick(); idle(); dmem_req = 1'b1;
    expect_out("latch_mem", 5'b00001, 4'b0001);
    tick(); muldiv_done = 1'b1;
    expect_out("latch_done", 5'b00001, 4'b0001);
    tick(); muldiv_done = 1'b0; dmem_ready = 1'b1;
    expect_out("latch_rel", 5'b11111, 4'b0000);
    tick(); idle(); ex_redirect = 1'b1;
    expect_out("latch_run", 5'b11111, 4'b1100);
    tick();

    // Watchdog: no muldiv_done.
    do_reset();
    ex_muldiv_start = 1'b1;
    tick(); idle();
    stalled = 0;
    for (int c = 0; c < MD_TIMEOUT; c++) begin
      @(negedge clk);
      if (!pc_en) stalled++;
      tick();
    end
    check("wd_stalled", 64'(stalled), 64'(MD_TIMEOUT));
    expect_out("wd_release", 5'b11111, 4'b0000);
    check("wd_err", 64'(md_timeout_err), 64'd1);
    check("wd_stall_cnt", 64'(stall_cycles), 64'(MD_TIMEOUT + 1));
    tick(); muldiv_done = 1'b1;
    tick(); idle(); tick(); tick();
    @(negedge clk);
    check("wd_sticky", 64'(md_timeout_err), 64'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    check("wd_cleared", 64'(md_timeout_err), 64'd0);
    tick();

    // Reset in the middle of a memory wait.
    do_reset();
    ex_redirect = 1'b1;
    tick(); idle(); dmem_req = 1'b1;
    tick(); tick();
    rst = 1'b1;
    expect_out("rstmem_hold", 5'b11111, 4'b0000);
    tick(); rst = 1'b0; idle();
    expect_out("rstmem_after", 5'b11111, 4'b0000);
    check("rstmem_stall_cnt", 64'(stall_cycles), 64'd0);
    check("rstmem_flush_cnt", 64'(flush_events), 64'd0);
    tick(); ex_redirect = 1'b1;
    expect_out("rstmem_run", 5'b11111, 4'b1100);
    tick();

    // Randomized run against the reference model.
    do_reset();
    m_in_mem = 0; m_md_busy = 0; m_err = 0; m_wd = 0; m_stall = 0; m_flush = 0;
    for (int n = 0; n < 3000; n++) begin
      rst             = ($urandom_range(0, 99) == 0);
      id_rs1_addr     = 5'($urandom_range(0, 3));
      id_rs2_addr     = 5'($urandom_range(0, 3));
      id_ex_rd_addr   = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      id_ex_memread   = 1'($urandom_range(0, 1));
      ex_redirect     = ($urandom_range(0, 3) == 0);
      ex_muldiv_start = ($urandom_range(0, 7) == 0);
      muldiv_done     = ($urandom_range(0, 5) == 0);
      dmem_req        = ($urandom_range(0, 3) == 0);
      dmem_ready      = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rnd_stall_cnt", 64'(stall_cycles), 64'(m_stall));
      check("rnd_flush_cnt", 64'(flush_events), 64'(m_flush));
      check("rnd_err", 64'(md_timeout_err), 64'(m_err));
      model_cycle(e_en, e_fl);
      check("rnd_en", 64'(en_v), 64'(e_en));
      check("rnd_fl", 64'(fl_v), 64'(e_fl));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
